// File: rtl/la_fifo_lane_splitter.sv
// Unpacks multi-lane FIFO entries into a one-lane-per-cycle valid/ready stream,
// skipping lanes whose mask bit is clear and flagging the last valid lane of each entry.
module la_fifo_lane_splitter #(
    parameter int LANES      = 2,
    parameter int LANE_WIDTH = 32,
    parameter int LANE_IDX_W = $clog2(LANES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        fifo_empty_i,
    input  logic [LANES*LANE_WIDTH-1:0] fifo_data_i,
    input  logic [LANES-1:0]            fifo_mask_i,
    output logic                        fifo_pop_o,
    output logic                        out_valid_o,
    output logic [LANE_WIDTH-1:0]       out_data_o,
    output logic [LANE_IDX_W-1:0]       out_lane_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                      state_p0;
    logic [LANES*LANE_WIDTH-1:0] data_p0;
    logic [LANES-1:0]            mask_p0;
    logic                        rst_done_p0;
    logic                        vld_p0;
    logic                        xfer;
    logic                        load;
    logic [LANES-1:0]            lane_oh;

    function automatic logic [LANES-1:0] lowest_oh(input logic [LANES-1:0] m);
        logic [LANES-1:0] r;
        r = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (m[k]) begin
                r    = '0;
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [LANE_IDX_W-1:0] lowest_idx(input logic [LANES-1:0] m);
        logic [LANE_IDX_W-1:0] r;
        r = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (m[k]) r = LANE_IDX_W'(k);
        end
        return r;
    endfunction

    function automatic logic single_bit(input logic [LANES-1:0] m);
        int n;
        n = 0;
        for (int k = 0; k < LANES; k++) n += int'(m[k]);
        return n == 1;
    endfunction

    // Output stage: everything presented downstream comes from held registers only
    assign vld_p0      = (state_p0 == HOLD);
    assign out_valid_o = vld_p0 & rst_n;
    assign out_lane_o  = lowest_idx(mask_p0);
    assign out_last_o  = out_valid_o & single_bit(mask_p0);
    assign lane_oh     = lowest_oh(mask_p0);

    always_comb begin
        out_data_o = data_p0[LANE_WIDTH-1:0];
        for (int k = 0; k < LANES; k++) begin
            if (lane_oh[k]) out_data_o = data_p0[k*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    // The last lane and the next pop share a cycle, so entries stream without bubbles.
    // rst_done_p0 keeps the pop quiet during the first cycle out of reset.
    assign xfer       = out_valid_o & out_ready_i;
    assign load       = (state_p0 == IDLE) | (xfer & out_last_o);
    assign fifo_pop_o = load & ~fifo_empty_i & ~flush_i & rst_n & rst_done_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0    <= IDLE;
            mask_p0     <= '0;
            rst_done_p0 <= 1'b0;
        end else begin
            rst_done_p0 <= 1'b1;
            if (flush_i) begin
                state_p0 <= IDLE;
                mask_p0  <= '0;
            end else if (fifo_pop_o) begin
                mask_p0  <= fifo_mask_i;
                state_p0 <= (|fifo_mask_i) ? HOLD : IDLE;
            end else if (load) begin
                state_p0 <= IDLE;
                mask_p0  <= '0;
            end else if (xfer) begin
                mask_p0  <= mask_p0 & ~lane_oh;
                state_p0 <= HOLD;
            end
        end
    end

    // Payload is only meaningful while HOLD, so it carries no reset
    always_ff @(posedge clk) begin
        if (fifo_pop_o) data_p0 <= fifo_data_i;
    end

endmodule

// File: tb/tb_la_fifo_lane_splitter.sv
// Bench for la_fifo_lane_splitter: an upstream FIFO model feeds entries and a lane
// scoreboard predicts pops, valid cycles and the exact lane sequence downstream.
module tb_la_fifo_lane_splitter;

    localparam int LANES = 2;
    localparam int LW    = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic            fifo_empty_i;
    logic [LANES*LW-1:0] fifo_data_i;
    logic [LANES-1:0]    fifo_mask_i;
    logic            fifo_pop_o;
    logic            out_valid_o;
    logic [LW-1:0]   out_data_o;
    logic [0:0]      out_lane_o;
    logic            out_last_o;
    logic            out_ready_i;

    always #5 clk = ~clk;

    la_fifo_lane_splitter #(.LANES(LANES), .LANE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_mask_i  (fifo_mask_i),
        .fifo_pop_o   (fifo_pop_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_lane_o   (out_lane_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i)
    );

    typedef struct packed {
        logic [LANES*LW-1:0] data;
        logic [LANES-1:0]    mask;
    } entry_t;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [0:0]    lane;
        logic          last;
    } lane_t;

    entry_t fifo_q[$];
    lane_t  exp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   hold_empty = 1'b0;
    logic   rst_done_m = 1'b0;
    logic   got_pop;
    logic   got_vld;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_entry(input logic [LW-1:0] b, input logic [LW-1:0] a, input logic [1:0] m);
        entry_t e;
        e.data = {b, a};
        e.mask = m;
        fifo_q.push_back(e);
    endtask

    // One clock: inputs are already applied; sample at negedge, advance past posedge
    task automatic cycle(output logic dut_pop, output logic dut_vld);
        logic   exp_pop;
        int     last_k;
        entry_t h;
        lane_t  l;
        fifo_empty_i = hold_empty || (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            h = fifo_q[0];
            fifo_data_i = h.data;
            fifo_mask_i = h.mask;
        end
        @(negedge clk);
        dut_pop = fifo_pop_o;
        dut_vld = out_valid_o;
        exp_pop = 1'b0;
        if (!rst_n) begin
            check("rst_valid", out_valid_o, 0);
            check("rst_last", out_last_o, 0);
            check("rst_pop", fifo_pop_o, 0);
            exp_q.delete();
        end else begin
            exp_pop = rst_done_m && !flush_i && !fifo_empty_i &&
                      (exp_q.size() == 0 || (out_ready_i && exp_q.size() == 1));
            check("pop", fifo_pop_o, exp_pop);
            check("pop_while_empty", fifo_pop_o & fifo_empty_i, 0);
            check("valid", out_valid_o, exp_q.size() != 0);
            if (out_valid_o && exp_q.size() != 0) begin
                l = exp_q[0];
                check("data", out_data_o, l.data);
                check("lane", out_lane_o, l.lane);
                check("last", out_last_o, l.last);
                if (out_ready_i) void'(exp_q.pop_front());
            end
            if (flush_i) exp_q.delete();
            if (exp_pop) begin
                h = fifo_q[0];
                last_k = -1;
                for (int k = 0; k < LANES; k++) if (h.mask[k]) last_k = k;
                for (int k = 0; k < LANES; k++) begin
                    if (h.mask[k]) begin
                        l.data = h.data[k*LW +: LW];
                        l.lane = 1'(k);
                        l.last = (k == last_k);
                        exp_q.push_back(l);
                    end
                end
            end
        end
        @(posedge clk);
        rst_done_m = rst_n;
        #1;
        if (exp_pop) void'(fifo_q.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(got_pop, got_vld);
    endtask

    initial begin
        int pops;
        int vlds;
        logic [3:0] pat_pop;
        logic [3:0] pat_vld;
        rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        fifo_data_i = '0; fifo_mask_i = '0; fifo_empty_i = 1'b1;
        push_entry(32'hDEAD0001, 32'hDEAD0000, 2'b11);
        run(3);
        rst_n = 1'b1;
        cycle(got_pop, got_vld);
        check("post_rst_pop", got_pop, 0);
        check("post_rst_valid", got_vld, 0);
        run(3);
        fifo_q.delete();
        run(2);

        // Two back-to-back entries: pop, lane0, lane1 + next pop
        push_entry(32'hBBBB0001, 32'hAAAA0000, 2'b11);
        push_entry(32'hDDDD0003, 32'hCCCC0002, 2'b11);
        pat_pop = 4'b0101;
        pat_vld = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            cycle(got_pop, got_vld);
            check("seq_pop", got_pop, pat_pop[i]);
            check("seq_valid", got_vld, pat_vld[i]);
        end
        run(3);

        // Sparse and empty masks
        push_entry(32'h10101010, 32'h01010101, 2'b10);
        push_entry(32'h20202020, 32'h02020202, 2'b00);
        push_entry(32'h30303030, 32'h03030303, 2'b01);
        push_entry(32'h40404040, 32'h04040404, 2'b11);
        run(9);

        // Backpressure holds lane0 stable, no pop
        push_entry(32'h5555B, 32'h5555A, 2'b11);
        cycle(got_pop, got_vld);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(got_pop, got_vld);
            check("bp_pop", got_pop, 0);
            check("bp_valid", got_vld, 1);
        end
        out_ready_i = 1'b1;
        run(3);

        // Continuous streaming: 10 entries, 20 lanes, no bubbles
        for (int i = 0; i < 10; i++) push_entry($urandom, $urandom, 2'b11);
        pops = 0; vlds = 0;
        for (int i = 0; i < 21; i++) begin
            cycle(got_pop, got_vld);
            pops += int'(got_pop);
            vlds += int'(got_vld);
        end
        check("stream_pops", pops, 10);
        check("stream_valids", vlds, 20);
        run(2);

        // Flush while lane1 is pending
        push_entry(32'h6666B, 32'h6666A, 2'b11);
        push_entry(32'h7777B, 32'h7777A, 2'b11);
        run(2);
        flush_i = 1'b1;
        cycle(got_pop, got_vld);
        check("flush_pop", got_pop, 0);
        check("flush_valid", got_vld, 1);
        flush_i = 1'b0;
        cycle(got_pop, got_vld);
        check("after_flush_valid", got_vld, 0);
        check("after_flush_pop", got_pop, 1);
        run(3);

        // Reset in the middle of an entry
        push_entry(32'h8888B, 32'h8888A, 2'b11);
        push_entry(32'h9999B, 32'h9999A, 2'b11);
        run(2);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        cycle(got_pop, got_vld);
        check("midrst_pop", got_pop, 0);
        check("midrst_valid", got_vld, 0);
        run(4);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(1, 0) == 1)
                push_entry($urandom, $urandom, 2'($urandom_range(3, 0)));
            hold_empty  = ($urandom_range(3, 0) == 0);
            out_ready_i = ($urandom_range(3, 0) != 0);
            flush_i     = ($urandom_range(31, 0) == 0);
            rst_n       = ($urandom_range(499, 0) != 0);
            cycle(got_pop, got_vld);
        end
        hold_empty = 1'b0; flush_i = 1'b0; rst_n = 1'b1; out_ready_i = 1'b1;
        run(12);
        check("drain_exp", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
